// File: rtl/mod_n_counter_pkg.sv
// ============================================================================
// Module   : mod_n_counter_pkg
// Brief    : Shared mode constants and step decode for the modulo-N counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_n_counter_pkg;

    localparam int EDGE_LEVEL  = 0;
    localparam int EDGE_RISING = 1;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_t;

    // Simultaneous up and down requests cancel into a hold.
    function automatic step_t decode_step(input logic up, input logic dn);
        step_t s;
        s = STEP_HOLD;
        if (up && !dn) begin
            s = STEP_UP;
        end else if (dn && !up) begin
            s = STEP_DOWN;
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_n_counter_edge_detect.sv
// ============================================================================
// Module   : mod_n_counter_edge_detect
// Brief    : Single-cycle pulse on each 0->1 transition of a level input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_n_counter_edge_detect (
    input  logic CLK,
    input  logic Reset,
    input  logic in,
    output logic pulse
);

    logic r_in_d;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_in_d <= 1'b0;
        end else begin
            r_in_d <= in;
        end
    end

    assign pulse = in & ~r_in_d;

endmodule

`default_nettype wire

// File: rtl/mod_n_counter.sv
// ============================================================================
// Module   : mod_n_counter
// Brief    : Modulo-N up/down counter with clamped load and cascade outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_n_counter
    import mod_n_counter_pkg::*;
#(
    parameter int MODULUS   = 4,
    parameter int WIDTH     = 2,
    parameter int EDGE_MODE = EDGE_LEVEL
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             INC,
    input  logic             DEC,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] Q,
    output logic             Carry,
    output logic             Borrow,
    output logic             AtMax,
    output logic             AtZero
);

    localparam logic [WIDTH:0]   c_mod_ext = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_max     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero    = '0;

    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
        $error("mod_n_counter: MODULUS %0d outside 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
    end

    if ((EDGE_MODE != EDGE_LEVEL) && (EDGE_MODE != EDGE_RISING)) begin : g_bad_edge_mode
        $error("mod_n_counter: EDGE_MODE %0d is not a known mode", EDGE_MODE);
    end

    logic             w_up;
    logic             w_dn;
    step_t            w_step;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] r_q;

    if (EDGE_MODE == EDGE_RISING) begin : g_edge
        mod_n_counter_edge_detect u_inc_edge (
            .CLK   (CLK),
            .Reset (Reset),
            .in    (INC),
            .pulse (w_up)
        );

        mod_n_counter_edge_detect u_dec_edge (
            .CLK   (CLK),
            .Reset (Reset),
            .in    (DEC),
            .pulse (w_dn)
        );
    end else begin : g_level
        assign w_up = INC;
        assign w_dn = DEC;
    end

    assign w_step    = decode_step(w_up, w_dn);
    assign w_at_max  = (r_q == c_max);
    assign w_at_zero = (r_q == c_zero);

    // Out-of-range load values clamp to the top of the count range.
    assign w_load_q = ({1'b0, LoadValue} < c_mod_ext) ? LoadValue : c_max;

    always_comb begin
        w_q_next = r_q;
        if (Load) begin
            w_q_next = w_load_q;
        end else begin
            case (w_step)
                STEP_UP:   w_q_next = w_at_max  ? c_zero : (r_q + c_one);
                STEP_DOWN: w_q_next = w_at_zero ? c_max  : (r_q - c_one);
                default:   w_q_next = r_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_q <= c_zero;
        end else begin
            r_q <= w_q_next;
        end
    end

    // Wrap flags lead Q by one cycle so the next digit steps on the same edge.
    assign Carry  = ~Reset & ~Load & (w_step == STEP_UP)   & w_at_max;
    assign Borrow = ~Reset & ~Load & (w_step == STEP_DOWN) & w_at_zero;

    assign Q      = r_q;
    assign AtMax  = w_at_max;
    assign AtZero = w_at_zero;

endmodule

`default_nettype wire

// File: doc/mod_n_counter.md
# mod_n_counter

Parametrised synchronous modulo-N up/down counter with parallel load, optional rising-edge qualification of the count inputs, and cascadable carry/borrow outputs. It generalises the 2-bit mod-4 increment counter for lab datapaths: multi-digit BCD/time-of-day counters, event counters fed by pushbuttons, and divider chains. One instance holds one digit; digits chain through Carry/Borrow.

## Interface
- MODULUS, 4: count range 0..MODULUS-1; legal range 2..2**WIDTH.
- WIDTH, 2: width of Q and LoadValue.
- EDGE_MODE, 0: 0 = INC/DEC are level enables (one step per cycle high); 1 = one step per 0→1 transition.

- CLK  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high.
- INC  input  1  count up request.
- DEC  input  1  count down request.
- Load  input  1  parallel load strobe.
- LoadValue  input  WIDTH  value for Load.
- Q  output  WIDTH  current count, registered.
- Carry  output  1  up-wrap indication, combinational.
- Borrow  output  1  down-wrap indication, combinational.
- AtMax  output  1  Q == MODULUS-1.
- AtZero  output  1  Q == 0.

## Operation
- Step events: EDGE_MODE=0: up = INC, dn = DEC. EDGE_MODE=1: up = INC & ~INC_d, dn = DEC & ~DEC_d; INC_d/DEC_d are registered copies updated every cycle (including Load cycles), cleared by Reset.
- Priority per edge: Reset > Load > step > hold.
- Reset: Q ← 0, INC_d ← 0, DEC_d ← 0.
- Load: Q ← LoadValue if LoadValue < MODULUS, else Q ← MODULUS-1 (clamp). No Carry/Borrow in a Load cycle.
- up & ~dn: Q ← (Q == MODULUS-1) ? 0 : Q+1.
- dn & ~up: Q ← (Q == 0) ? MODULUS-1 : Q-1.
- up & dn: hold; no Carry/Borrow.
- Carry = ~Reset & ~Load & up & ~dn & (Q == MODULUS-1).
- Borrow = ~Reset & ~Load & dn & ~up & (Q == 0).
- Q never takes a value ≥ MODULUS; all arithmetic in WIDTH bits, no overflow path.
- Cascade: digit k+1 INC ← digit k Carry, DEC ← digit k Borrow; downstream digits use EDGE_MODE=0.

## Timing
- Q: one cycle latency from step/Load/Reset to new value; reset value 0.
- AtMax/AtZero: decode of registered Q; reset values AtMax=0 (MODULUS≥2), AtZero=1.
- Carry/Borrow: valid in the same cycle as the step causing the wrap, i.e. before Q shows 0/MODULUS-1; 0 during Reset.
- EDGE_MODE=1: INC held high for N cycles gives exactly one step; INC high through Reset deassertion gives one step on the first post-reset cycle (INC_d cleared).
- Reset mid-count: overrides all inputs that edge; counting resumes next cycle.
- No combinational path from Carry back into the same instance.

## Structure
- Shared include file: mode constants EDGE_LEVEL=0, EDGE_RISING=1.
- Sub-module edge_detect (CLK, Reset, in, pulse): one per count input, instantiated under generate when EDGE_MODE=1; bypassed otherwise.
- Top: next-state mux with priority chain, registered Q, Carry/Borrow/AtMax/AtZero decode.
- Parameter check: simulation-time error if MODULUS > 2**WIDTH or MODULUS < 2.

## Test plan
- MODULUS=10, WIDTH=4, EDGE_MODE=0: Reset then INC high 12 cycles → Q 1..9,0,1,2; Carry high only in the cycle Q=9.
- Same config: from Q=0, DEC high 1 cycle → Borrow high that cycle, Q=9 next; AtMax=1.
- Load LoadValue=7 → Q=7; LoadValue=13 → Q=9; Load with INC high same cycle → Q=LoadValue, Carry=0.
- INC and DEC both high 5 cycles at Q=4 → Q stays 4, Carry=Borrow=0.
- EDGE_MODE=1, MODULUS=4: INC high 6 cycles, low 2, high 1 → Q goes 0→1 then 1→2 only; Reset asserted while INC high at Q=3 → Q=0, then Q=1 one cycle after Reset drops.
- Two cascaded MODULUS=10 digits: 100 INC cycles from 00 → tens/ones wrap 99→00, tens Carry high exactly once.
